ram_sdp_param: RTL

RAM_SDP_PARAM -- requirements
Module: ram_sdp_param

---
 rtl/ram_sdp_param.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ram_sdp_param.sv
// Simple dual-port RAM with byte-enable writes, a power-on/on-demand clear walker,
// selectable read/write collision behaviour and an optional extra output register.
module ram_sdp_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned RD_MODE = 0,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [DATA_W-1:0]     data,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     read_addr,
  input  logic                  clr,
  output logic [DATA_W-1:0]     q,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   q_q;
  logic                q_valid_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_fire;
  logic                rd_fire;
  logic [DATA_W-1:0]   rd_old;
  logic [DATA_W-1:0]   rd_merged;
  logic [DATA_W-1:0]   rd_word;

  // Clear walker: next state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign wr_fire = (state_q == READY) && we && !rst;
  assign rd_fire = (state_q == READY) && re && !rst;

  // Array: the walker owns the write port while clearing
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[write_addr][8*b +: 8] <= data[8*b +: 8];
      end
    end
  end

  assign rd_old = mem[read_addr];

  // Word as it will look after this cycle's write lands
  always_comb begin
    rd_merged = rd_old;
    for (int unsigned b = 0; b < NB; b++) begin
      if (be[b]) rd_merged[8*b +: 8] = data[8*b +: 8];
    end
  end

  assign rd_word = ((RD_MODE != 0) && we && (write_addr == read_addr)) ? rd_merged : rd_old;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] s1_data_q;
      logic              s1_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_data_q  <= '0;
          s1_valid_q <= 1'b0;
          q_q        <= '0;
          q_valid_q  <= 1'b0;
        end else begin
          s1_valid_q <= rd_fire;
          if (rd_fire) s1_data_q <= rd_word;
          q_valid_q  <= s1_valid_q;
          if (s1_valid_q) q_q <= s1_data_q;
        end
      end
    end else begin : g_no_out_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          q_q       <= '0;
          q_valid_q <= 1'b0;
        end else begin
          q_valid_q <= rd_fire;
          if (rd_fire) q_q <= rd_word;
        end
      end
    end
  endgenerate

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = busy_q;

endmodule
